// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: glyph table, blank pattern, phase count.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    // Brightness phases per digit slot; phase 0 is always the anti-ghosting gap.
    localparam int BRIGHT_PHASES = 16;
    localparam logic [3:0] LAST_PHASE = 4'(BRIGHT_PHASES - 1);

    // All segments dark, decimal point dark (active-low pins).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs, entry n is hex digit n (lower-case b and d).
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/display_mux_7seg_if.sv
// Bundle of digit data/controls into the scanner and the pin-level drive coming out.
// Latency: n/a (wiring only).
// Backpressure: none; inputs are sampled once per frame, outputs are free-running.
interface display_mux_7seg_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz_blank;
    logic [3:0]              brightness;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   digit;
    logic                    frame_start;

    // Source of digit values (counting logic / bench).
    modport master (
        output data, dp, lz_blank, brightness,
        input  seg, digit, frame_start
    );

    // The scanner itself.
    modport slave (
        input  data, dp, lz_blank, brightness,
        output seg, digit, frame_start
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble + decimal point to active-low {dp,g,f,e,d,c,b,a} pattern.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);
    assign seg = {~dp, GLYPHS[nibble]};
endmodule

// File: rtl/display_mux_7seg.sv
// Time-multiplexed common-anode 7-seg scanner with LZ blanking, 16-level PWM and gap phase.
// Latency: SEG/DIGIT registered, 1 cycle after counters; inputs take effect at next frame snapshot.
// Backpressure: none; free-running scan, inputs are snapshotted once per frame.
module display_mux_7seg
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PHASE_LEN  = 3125
) (
    input  logic                   clk,
    input  logic                   rst,
    display_mux_7seg_if.slave      bus
);
    localparam int PC_W   = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam int SLOT_W = $clog2(NUM_DIGITS);

    logic [PC_W-1:0]         phase_cnt_q, phase_cnt_d;
    logic [3:0]              phase_q, phase_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    lz_q, lz_d;
    logic [3:0]              bright_q, bright_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic                    frame_start_q, frame_start_d;

    logic                    snapshot;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    zero_run;
    logic [7:0]              dec_seg;

    // Single decoder on the nibble of the slot currently being scanned.
    hex_to_seg7 u_dec (
        .nibble (data_q[4*slot_q +: 4]),
        .dp     (dp_q[slot_q]),
        .seg    (dec_seg)
    );

    // Leading-zero blanking from shadow values: walk down from the top digit, digit 0 always shown.
    always_comb begin
        blank_vec = '0;
        zero_run  = lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && (data_q[4*i +: 4] == 4'h0) && !dp_q[i];
            blank_vec[i] = zero_run;
        end
    end

    // Counter advance, frame snapshot and next output pattern for the current (slot, phase).
    always_comb begin
        phase_cnt_d   = phase_cnt_q + 1'b1;
        phase_d       = phase_q;
        slot_d        = slot_q;
        snapshot      = (slot_q == '0) && (phase_q == 4'd0) && (phase_cnt_q == '0);
        data_d        = data_q;
        dp_d          = dp_q;
        lz_d          = lz_q;
        bright_d      = bright_q;
        seg_d         = SEG_OFF;
        digit_d       = '1;
        frame_start_d = snapshot;

        if (phase_cnt_q == PC_W'(PHASE_LEN - 1)) begin
            phase_cnt_d = '0;
            phase_d     = phase_q + 4'd1;
            if (phase_q == LAST_PHASE) begin
                slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
            end
        end

        if (snapshot) begin
            data_d   = bus.data;
            dp_d     = bus.dp;
            lz_d     = bus.lz_blank;
            bright_d = bus.brightness;
        end

        // Phase 0 is the gap; a blanked digit stays enabled so every digit gets equal on-time.
        if ((phase_q != 4'd0) && (phase_q <= bright_q)) begin
            digit_d[slot_q] = 1'b0;
            seg_d           = blank_vec[slot_q] ? SEG_OFF : dec_seg;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt_q   <= '0;
            phase_q       <= '0;
            slot_q        <= '0;
            data_q        <= '0;
            dp_q          <= '0;
            lz_q          <= 1'b0;
            bright_q      <= '0;
            seg_q         <= SEG_OFF;
            digit_q       <= '1;
            frame_start_q <= 1'b0;
        end else begin
            phase_cnt_q   <= phase_cnt_d;
            phase_q       <= phase_d;
            slot_q        <= slot_d;
            data_q        <= data_d;
            dp_q          <= dp_d;
            lz_q          <= lz_d;
            bright_q      <= bright_d;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.digit       = digit_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
module tb_display_mux_7seg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_mux_7seg_if #(.NUM_DIGITS(4)) if4 ();
    display_mux_7seg_if #(.NUM_DIGITS(8)) if8 ();

    display_mux_7seg #(.NUM_DIGITS(4), .PHASE_LEN(2)) u4 (.clk(clk), .rst(rst), .bus(if4));
    display_mux_7seg #(.NUM_DIGITS(8), .PHASE_LEN(1)) u8 (.clk(clk), .rst(rst), .bus(if8));

    int errors = 0;
    int checks = 0;

    // Active-high gfedcba shapes of 0..F, written the way a datasheet lists them.
    logic [6:0] shape [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected pins for a position within a frame, from the display rules.
    function automatic void model_out(input int n, input int pl, input int pos,
                                      input logic [31:0] d, input logic [7:0] dp,
                                      input logic lz, input logic [3:0] br,
                                      output logic [7:0] seg, output logic [7:0] dig);
        int slot, phase, top;
        logic [3:0] nib;
        slot  = pos / (16 * pl);
        phase = (pos / pl) % 16;
        seg   = 8'hFF;
        dig   = 8'hFF;
        if (phase != 0 && phase <= int'(br)) begin
            dig[slot] = 1'b0;
            top = 0;
            for (int i = 0; i < n; i++)
                if (d[4*i +: 4] != 4'h0 || dp[i]) top = i;
            nib = d[4*slot +: 4];
            if (lz && slot > top) seg = 8'hFF;
            else seg = {~dp[slot], ~shape[nib]};
        end
    endfunction

    // Behavioural model: position k counts edges since reset release; frame boundary snapshots inputs.
    int k = -1;
    int pos4, pos8;
    bit mvalid = 0;
    logic [31:0] sd4, sd8;
    logic [7:0]  sp4, sp8, es4, ed4, es8, ed8;
    logic        sl4, sl8, ef;
    logic [3:0]  sb4, sb8;

    always @(posedge clk) begin
        if (rst) begin
            k = -1; sd4 = 0; sd8 = 0; sp4 = 0; sp8 = 0; sl4 = 0; sl8 = 0; sb4 = 0; sb8 = 0;
            es4 = 8'hFF; ed4 = 8'hFF; es8 = 8'hFF; ed8 = 8'hFF; ef = 0;
            mvalid = 1;
        end else begin
            k++;
            pos4 = k % (16 * 2 * 4);
            pos8 = k % (16 * 1 * 8);
            if (pos4 == 0) begin
                sd4 = {16'h0, if4.data}; sp4 = {4'h0, if4.dp};
                sl4 = if4.lz_blank; sb4 = if4.brightness;
            end
            if (pos8 == 0) begin
                sd8 = if8.data; sp8 = if8.dp; sl8 = if8.lz_blank; sb8 = if8.brightness;
            end
            ef = (pos4 == 0);
            model_out(4, 2, pos4, sd4, sp4, sl4, sb4, es4, ed4);
            model_out(8, 1, pos8, sd8, sp8, sl8, sb8, es8, ed8);
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("u4_seg", 32'(if4.seg), 32'(es4));
            chk("u4_digit", 32'(if4.digit), 32'(ed4[3:0]));
            chk("u4_frame_start", 32'(if4.frame_start), 32'(ef));
            chk("u8_seg", 32'(if8.seg), 32'(es8));
            chk("u8_digit", 32'(if8.digit), 32'(ed8));
            chk("u8_frame_start", 32'(if8.frame_start), 32'(ef));
            chk("u8_one_cold", 32'($countones(~if8.digit) <= 1), 32'd1);
        end
    end

    // Random traffic on the 8-digit instance, biased toward leading zeros.
    initial begin
        if8.data = 0; if8.dp = 0; if8.lz_blank = 0; if8.brightness = 4'd15;
        forever begin
            @(negedge clk);
            if8.data       = $urandom >> $urandom_range(0, 31);
            if8.dp         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if8.lz_blank   = 1'($urandom_range(0, 1));
            if8.brightness = 4'($urandom_range(0, 15));
        end
    end

    // Per-frame observations of the 4-digit instance.
    int         cnt4   [4];
    int         first4 [4];
    logic [7:0] seg4   [4];
    int         chg_at = -1;
    logic [15:0] chg_val = 16'h0;

    // Observe one whole frame; the next negedge must be frame position 0.
    task automatic run_frame4();
        for (int i = 0; i < 4; i++) begin
            cnt4[i] = 0; first4[i] = -1; seg4[i] = 8'h00;
        end
        for (int c = 0; c < 128; c++) begin
            @(negedge clk);
            if (c == 0) chk("frame_start_at_pos0", 32'(if4.frame_start), 32'd1);
            for (int i = 0; i < 4; i++) begin
                if (if4.digit == ~(4'b0001 << i)) begin
                    cnt4[i]++;
                    seg4[i] = if4.seg;
                    if (first4[i] < 0) first4[i] = c;
                end
            end
            if (c == chg_at) if4.data = chg_val;
        end
    endtask

    initial begin
        if4.data = 16'h1234; if4.dp = 4'b0000; if4.lz_blank = 1'b0; if4.brightness = 4'd15;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(if4.seg), 32'hFF);
        chk("reset_digit", 32'(if4.digit), 32'hF);
        chk("reset_frame_start", 32'(if4.frame_start), 32'd0);
        rst = 1'b0;

        // Frame 0: 1234 at full brightness, gap of 2 cycles then 30 lit.
        run_frame4();
        chk("f0_first_d0", first4[0], 2);
        chk("f0_first_d3", first4[3], 98);
        for (int i = 0; i < 4; i++) chk("f0_on_cycles", cnt4[i], 30);
        chk("f0_seg_d0_4", 32'(seg4[0]), 32'h99);
        chk("f0_seg_d1_3", 32'(seg4[1]), 32'hB0);
        chk("f0_seg_d2_2", 32'(seg4[2]), 32'hA4);
        chk("f0_seg_d3_1", 32'(seg4[3]), 32'hF9);

        if4.brightness = 4'd0;
        run_frame4();
        for (int i = 0; i < 4; i++) chk("bright0_on_cycles", cnt4[i], 0);

        if4.brightness = 4'd4;
        run_frame4();
        for (int i = 0; i < 4; i++) chk("bright4_on_cycles", cnt4[i], 8);

        if4.data = 16'h0070; if4.lz_blank = 1'b1; if4.brightness = 4'd15;
        run_frame4();
        chk("lz_d3_enabled", cnt4[3], 30);
        chk("lz_d3_blank", 32'(seg4[3]), 32'hFF);
        chk("lz_d2_blank", 32'(seg4[2]), 32'hFF);
        chk("lz_d1_7", 32'(seg4[1]), 32'hF8);
        chk("lz_d0_0", 32'(seg4[0]), 32'hC0);

        if4.data = 16'h0000;
        run_frame4();
        chk("lz_all0_d0", 32'(seg4[0]), 32'hC0);
        chk("lz_all0_d1", 32'(seg4[1]), 32'hFF);

        if4.dp = 4'b0100;
        run_frame4();
        chk("lz_dp_d2", 32'(seg4[2]), 32'h40);
        chk("lz_dp_d3", 32'(seg4[3]), 32'hFF);
        chk("lz_dp_d1", 32'(seg4[1]), 32'hC0);

        // No tearing: change mid-frame, current frame keeps 1s.
        if4.data = 16'h1111; if4.dp = 4'b0000; if4.lz_blank = 1'b0;
        run_frame4();
        chg_at = 40; chg_val = 16'h2222;
        run_frame4();
        chg_at = -1;
        for (int i = 0; i < 4; i++) chk("tear_old_frame", 32'(seg4[i]), 32'hF9);
        run_frame4();
        for (int i = 0; i < 4; i++) chk("tear_new_frame", 32'(seg4[i]), 32'hA4);

        // Reset pulse while slot 2 is being scanned.
        repeat (71) @(negedge clk);
        chk("midrst_in_slot2", 32'(if4.digit), 32'b1011);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_seg", 32'(if4.seg), 32'hFF);
        chk("midrst_digit", 32'(if4.digit), 32'hF);
        chk("midrst_frame_start", 32'(if4.frame_start), 32'd0);
        rst = 1'b0;
        run_frame4();
        chk("after_rst_d0_on", cnt4[0], 30);
        chk("after_rst_d0_2", 32'(seg4[0]), 32'hA4);
        run_frame4();
        chk("after_rst_d3_2", 32'(seg4[3]), 32'hA4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
